// File: rtl/icache_ins_ram.sv
// Simple dual-port instruction-cache RAM: one write port, one registered read port, read-first on collision.
// Optional macro ICACHE_RAM_OUTREG_EN adds a second output register (read latency 2 instead of 1).
module icache_ins_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Array is never cleared; reset only blocks the write so refill state survives.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read against the same edge's write gives read-first collision behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

`ifdef ICACHE_RAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] out_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= rd_q;
        end
    end

    assign rd_data = out_q;
`else
    assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_icache_ins_ram.sv
// Directed self-checking bench for icache_ins_ram; honours ICACHE_RAM_OUTREG_EN for the read latency.
module tb_icache_ins_ram;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 2 ** AW;
`ifdef ICACHE_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    int compared   = 0;
    int mismatched = 0;

    // Reference image plus a pipeline of expected read results, advanced once per edge.
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] pipe0;
    logic [DW-1:0] pipe1;
    logic [DW-1:0] expected;

    icache_ins_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge: the reference reads before it writes, then outputs are sampled 1ns later.
    task automatic applyStimulus();
        @(posedge clk);
        if (!rst_n) begin
            pipe0 = '0;
            pipe1 = '0;
        end else begin
            pipe1 = pipe0;
            pipe0 = model[rd_addr];
            if (wr_en) model[wr_addr] = wr_data;
        end
        expected = (LAT == 1) ? pipe0 : pipe1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] exp_val);
        compared++;
        assert (rd_data === exp_val)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: rd_data=%h expected=%h", tag, rd_data, exp_val);
        end
    endtask

    function automatic logic [DW-1:0] fill_word(input int idx);
        logic [DW-1:0] base;
        base = 32'hFFFF_FFFF;
        return base - DW'(idx);
    endfunction

    initial begin
        logic [AW:0] cnt;

        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = AW'(5);
        wr_data = 32'hDEAD_BEEF;
        rd_addr = AW'(5);
        pipe0   = '0;
        pipe1   = '0;
        #2;

        $display("[TB] reset hold with write to addr 5 pending");
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            checkOutput("reset_hold", '0);
        end

        rst_n = 1'b1;
        wr_en = 1'b0;
        for (int i = 0; i < LAT; i++) applyStimulus();
        compared++;
        assert (rd_data !== 32'hDEAD_BEEF)
        else begin
            mismatched++;
            $error("[TB] FAIL reset_write_suppressed: rd_data=%h expected not deadbeef", rd_data);
        end

        $display("[TB] full fill 1..1023 then 0 via 11-bit counter");
        cnt   = '0;
        wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cnt     = cnt + 1'b1;
            wr_addr = cnt[AW-1:0];
            wr_data = fill_word(i);
            applyStimulus();
        end
        wr_en = 1'b0;

        $display("[TB] back-to-back readback");
        cnt = '0;
        for (int c = 0; c < DEPTH + LAT - 1; c++) begin
            if (c < DEPTH) begin
                cnt     = cnt + 1'b1;
                rd_addr = cnt[AW-1:0];
            end
            applyStimulus();
            if (c >= LAT - 1) begin
                automatic int idx = c - (LAT - 1);
                checkOutput($sformatf("readback_%0d", idx), fill_word(idx));
            end
        end

        rd_addr = '0;
        applyStimulus();
        for (int i = 0; i < LAT - 1; i++) applyStimulus();
        checkOutput("addr0_wrap", 32'hFFFF_FC00);

        $display("[TB] read-during-write on addr 7");
        wr_en   = 1'b1;
        wr_addr = AW'(7);
        wr_data = 32'h1111_1111;
        rd_addr = '0;
        applyStimulus();
        wr_data = 32'h2222_2222;
        rd_addr = AW'(7);
        applyStimulus();
        wr_en = 1'b0;
        for (int i = 0; i < LAT - 1; i++) applyStimulus();
        checkOutput("rdw_old", 32'h1111_1111);
        applyStimulus();
        checkOutput("rdw_new", 32'h2222_2222);

        $display("[TB] independent ports");
        wr_en   = 1'b1;
        wr_addr = AW'(200);
        wr_data = 32'h00C0_FFEE;
        rd_addr = '0;
        applyStimulus();
        wr_addr = AW'(100);
        wr_data = 32'hA5A5_A5A5;
        rd_addr = AW'(200);
        applyStimulus();
        wr_en = 1'b0;
        for (int i = 0; i < LAT - 1; i++) applyStimulus();
        checkOutput("indep_read200", 32'h00C0_FFEE);
        rd_addr = AW'(100);
        for (int i = 0; i < LAT; i++) applyStimulus();
        checkOutput("indep_read100", 32'hA5A5_A5A5);

        $display("[TB] mid-stream reset during sequential read");
        for (int c = 0; c < 40; c++) begin
            rd_addr = AW'(c + 10);
            rst_n   = (c != 20);
            wr_en   = (c == 20);
            wr_addr = AW'(3);
            wr_data = '0;
            applyStimulus();
            if (c == 20) checkOutput("midreset_zero", '0);
            else if (c >= LAT - 1) checkOutput($sformatf("midreset_stream_%0d", c), expected);
        end
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_addr = AW'(3);
        for (int i = 0; i < LAT; i++) applyStimulus();
        checkOutput("midreset_addr3_kept", 32'hFFFF_FFFD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
